// File: rtl/switch_forwarding_engine_if.sv
// Port-side and CAM-side signal bundle of the switch forwarding engine.
// The engine connects through the master modport; port wrappers and CAM see the slave view.
interface switch_forwarding_engine_if #(
    parameter int unsigned NUMBER_OF_PORTS = 4
);
    localparam int unsigned PW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;

    logic [NUMBER_OF_PORTS-1:0]      port_enable_mask;
    logic [NUMBER_OF_PORTS-1:0]      port_receive_data_valid;
    logic [NUMBER_OF_PORTS-1:0][8:0] port_receive_data;
    logic [NUMBER_OF_PORTS-1:0]      port_receive_data_ready;
    logic [8:0]                      port_transmit_data;
    logic [NUMBER_OF_PORTS-1:0]      port_transmit_data_valid;
    logic [47:0]                     cam_lookup_key;
    logic                            cam_lookup_valid;
    logic                            cam_match_valid;
    logic [PW-1:0]                   cam_match_index;
    logic                            cam_no_match;
    logic [47:0]                     cam_write_key;
    logic [PW-1:0]                   cam_write_index;
    logic                            cam_write_valid;

    modport master (
        input  port_enable_mask, port_receive_data_valid, port_receive_data,
        input  cam_match_valid, cam_match_index, cam_no_match,
        output port_receive_data_ready, port_transmit_data, port_transmit_data_valid,
        output cam_lookup_key, cam_lookup_valid, cam_write_key, cam_write_index, cam_write_valid
    );

    modport slave (
        output port_enable_mask, port_receive_data_valid, port_receive_data,
        output cam_match_valid, cam_match_index, cam_no_match,
        input  port_receive_data_ready, port_transmit_data, port_transmit_data_valid,
        input  cam_lookup_key, cam_lookup_valid, cam_write_key, cam_write_index, cam_write_valid
    );
endinterface

// File: rtl/switch_forwarding_engine.sv
// Round-robin frame forwarder: buffers the MAC header, looks up/learns via the CAM,
// then replays the header and streams the payload to the resolved egress port mask.
module switch_forwarding_engine #(
    parameter int unsigned NUMBER_OF_PORTS = 4,
    parameter int unsigned LOOKUP_TIMEOUT  = 15,
    parameter int unsigned COUNTER_WIDTH   = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    switch_forwarding_engine_if.master bus,
    output logic [COUNTER_WIDTH-1:0] forwarded_count,
    output logic [COUNTER_WIDTH-1:0] flooded_count,
    output logic [COUNTER_WIDTH-1:0] dropped_count
);
    localparam int unsigned N  = NUMBER_OF_PORTS;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(LOOKUP_TIMEOUT + 1);
    localparam int unsigned CW = COUNTER_WIDTH;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HEADER, ST_LOOKUP, ST_LEARN, ST_REPLAY, ST_STREAM, ST_DRAIN
    } state_t;
    typedef enum logic [1:0] {CAT_FWD, CAT_FLD, CAT_DRP} cat_t;

    state_t           state_q, state_d;
    cat_t             cat_q, cat_d, route_cat, done_cat;
    logic [PW-1:0]    grant_q, grant_d, ptr_q, ptr_d, write_index_q, write_index_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [11:0][7:0] hdr_q, hdr_d;
    logic             last_q, last_d;
    logic [N-1:0]     mask_q, mask_d, ready_q, ready_d, tx_valid_q, tx_valid_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [8:0]       tx_data_q, tx_data_d;
    logic             lookup_valid_q, lookup_valid_d, write_valid_q, write_valid_d;
    logic [47:0]      lookup_key_q, lookup_key_d, write_key_q, write_key_d;
    logic [CW-1:0]    fwd_q, fwd_d, fld_q, fld_d, drp_q, drp_d;

    logic [N-1:0] grant_oh, requests, route_mask;
    logic [8:0]   rx_byte;
    logic         rx_fire, found, start_egress, frame_done, resolved;
    int unsigned  cand;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d        = state_q;
        cat_d          = cat_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        hdr_d          = hdr_q;
        last_d         = last_q;
        mask_d         = mask_q;
        timer_d        = timer_q;
        tx_data_d      = '0;
        tx_valid_d     = '0;
        lookup_valid_d = 1'b0;
        lookup_key_d   = lookup_key_q;
        write_valid_d  = 1'b0;
        write_key_d    = write_key_q;
        write_index_d  = write_index_q;
        fwd_d          = fwd_q;
        fld_d          = fld_q;
        drp_d          = drp_q;
        route_mask     = '0;
        route_cat      = CAT_DRP;
        done_cat       = cat_q;
        found          = 1'b0;
        cand           = 0;
        start_egress   = 1'b0;
        frame_done     = 1'b0;
        resolved       = 1'b0;
        grant_oh       = ONE << grant_q;
        requests       = bus.port_receive_data_valid & bus.port_enable_mask;
        rx_byte        = bus.port_receive_data[grant_q];
        rx_fire        = bus.port_receive_data_valid[grant_q] & ready_q[grant_q];

        case (state_q)
            ST_IDLE: begin
                for (int unsigned i = 1; i <= N; i++) begin
                    cand = (32'(ptr_q) + i) % N;
                    if (!found && requests[PW'(cand)]) begin
                        found   = 1'b1;
                        grant_d = PW'(cand);
                    end
                end
                if (found) begin
                    ptr_d   = grant_d;
                    cnt_d   = '0;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (rx_fire) begin
                    hdr_d[cnt_q] = rx_byte[7:0];
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd11) begin
                        last_d         = rx_byte[8];
                        timer_d        = '0;
                        lookup_valid_d = 1'b1;
                        lookup_key_d   = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
                        state_d        = ST_LOOKUP;
                    end else if (rx_byte[8]) begin
                        frame_done = 1'b1;
                        done_cat   = CAT_DRP;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_LOOKUP: begin
                timer_d  = timer_q + TW'(1);
                resolved = bus.cam_match_valid || bus.cam_no_match || (timer_q == TW'(LOOKUP_TIMEOUT));
                if (resolved) begin
                    // Group-addressed or unknown destinations flood; a hit never returns to its ingress
                    if (hdr_q[0][0] || !bus.cam_match_valid) begin
                        route_mask = bus.port_enable_mask & ~grant_oh;
                        route_cat  = CAT_FLD;
                    end else begin
                        route_mask = (ONE << bus.cam_match_index) & bus.port_enable_mask & ~grant_oh;
                        route_cat  = CAT_FWD;
                    end
                    mask_d = route_mask;
                    cat_d  = (route_mask == '0) ? CAT_DRP : route_cat;
                    if (!hdr_q[6][0]) begin
                        write_valid_d = 1'b1;
                        write_key_d   = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
                        write_index_d = grant_q;
                        state_d       = ST_LEARN;
                    end else begin
                        start_egress = 1'b1;
                    end
                end
            end
            ST_LEARN: start_egress = 1'b1;
            ST_REPLAY: begin
                if (cnt_q == 4'd11) begin
                    frame_done = last_q;
                    state_d    = last_q ? ST_IDLE : ST_STREAM;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    tx_data_d  = {last_q && (cnt_q == 4'd10), hdr_q[cnt_q + 4'd1]};
                    tx_valid_d = mask_q;
                end
            end
            ST_STREAM: begin
                if (rx_fire) begin
                    tx_data_d  = rx_byte;
                    tx_valid_d = mask_q;
                    if (rx_byte[8]) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_fire && rx_byte[8]) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // First header byte goes out on the cycle after the route is known
        if (start_egress) begin
            done_cat = cat_d;
            if (mask_d == '0) begin
                frame_done = last_q;
                state_d    = last_q ? ST_IDLE : ST_DRAIN;
            end else begin
                cnt_d      = '0;
                tx_data_d  = {1'b0, hdr_q[0]};
                tx_valid_d = mask_d;
                state_d    = ST_REPLAY;
            end
        end

        if (frame_done) begin
            case (done_cat)
                CAT_FWD: fwd_d = sat_inc(fwd_q);
                CAT_FLD: fld_d = sat_inc(fld_q);
                default: drp_d = sat_inc(drp_q);
            endcase
        end

        ready_d = '0;
        if (state_d == ST_HEADER || state_d == ST_STREAM || state_d == ST_DRAIN) begin
            ready_d = ONE << grant_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cat_q          <= CAT_FWD;
            grant_q        <= '0;
            ptr_q          <= PW'(N - 1);
            cnt_q          <= '0;
            hdr_q          <= '0;
            last_q         <= 1'b0;
            mask_q         <= '0;
            timer_q        <= '0;
            ready_q        <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= '0;
            lookup_valid_q <= 1'b0;
            lookup_key_q   <= '0;
            write_valid_q  <= 1'b0;
            write_key_q    <= '0;
            write_index_q  <= '0;
            fwd_q          <= '0;
            fld_q          <= '0;
            drp_q          <= '0;
        end else begin
            state_q        <= state_d;
            cat_q          <= cat_d;
            grant_q        <= grant_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            hdr_q          <= hdr_d;
            last_q         <= last_d;
            mask_q         <= mask_d;
            timer_q        <= timer_d;
            ready_q        <= ready_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            lookup_valid_q <= lookup_valid_d;
            lookup_key_q   <= lookup_key_d;
            write_valid_q  <= write_valid_d;
            write_key_q    <= write_key_d;
            write_index_q  <= write_index_d;
            fwd_q          <= fwd_d;
            fld_q          <= fld_d;
            drp_q          <= drp_d;
        end
    end

    assign bus.port_receive_data_ready  = ready_q;
    assign bus.port_transmit_data       = tx_data_q;
    assign bus.port_transmit_data_valid = tx_valid_q;
    assign bus.cam_lookup_key           = lookup_key_q;
    assign bus.cam_lookup_valid         = lookup_valid_q;
    assign bus.cam_write_key            = write_key_q;
    assign bus.cam_write_index          = write_index_q;
    assign bus.cam_write_valid          = write_valid_q;
    assign forwarded_count              = fwd_q;
    assign flooded_count                = fld_q;
    assign dropped_count                = drp_q;
endmodule

// File: tb/tb_switch_forwarding_engine.sv
// Self-checking bench: table of frames with hand-derived egress masks and counter values,
// a behavioural CAM, per-port ingress queues and an egress scoreboard.
module tb_switch_forwarding_engine;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] fwd_cnt, fld_cnt, drp_cnt;

    always #5 clk = ~clk;

    switch_forwarding_engine_if #(.NUMBER_OF_PORTS(N)) bus ();

    switch_forwarding_engine #(
        .NUMBER_OF_PORTS(N), .LOOKUP_TIMEOUT(15), .COUNTER_WIDTH(CW)
    ) dut (
        .clock(clk), .reset_n(rst_n), .bus(bus),
        .forwarded_count(fwd_cnt), .flooded_count(fld_cnt), .dropped_count(drp_cnt)
    );

    typedef struct packed { logic [8:0] data; logic [3:0] mask; } egr_t;
    typedef struct {
        int          port;
        logic [47:0] dst;
        logic [47:0] src;
        int          plen;
        logic [3:0]  en;
        bit          silent;
        logic [3:0]  exp_mask;
        bit          exp_learn;
        logic [1:0]  exp_fwd, exp_fld, exp_drp;
    } vec_t;

    logic [8:0]  rxq [N][$];
    bit          fired [N];
    bit          in_frame [N];
    egr_t        sbq [$];
    int          grant_log [$];
    int          cam_tab [logic [47:0]];
    bit          cam_silent = 1'b0;
    int          lookups = 0, writes = 0, cyc = 0, lookup_cyc = 0, first_tx_cyc = 0;
    bit          armed = 1'b0;
    logic [47:0] last_wkey = '0, last_lkey = '0;
    logic [1:0]  last_widx = '0;
    int          errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ingress driver, CAM model and egress scoreboard, all acting on the falling edge
    initial begin
        logic [8:0] b;
        egr_t       e;
        bus.port_receive_data_valid = '0;
        bus.port_receive_data       = '0;
        bus.cam_match_valid         = 1'b0;
        bus.cam_no_match            = 1'b0;
        bus.cam_match_index         = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.cam_match_valid = 1'b0;
            bus.cam_no_match    = 1'b0;
            if (!rst_n) begin
                for (int p = 0; p < N; p++) begin
                    fired[p]    = 1'b0;
                    in_frame[p] = 1'b0;
                end
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (fired[p]) begin
                        b = rxq[p].pop_front();
                        if (!in_frame[p]) grant_log.push_back(p);
                        in_frame[p] = !b[8];
                    end
                end
                if (bus.port_transmit_data_valid != '0) begin
                    if (armed) begin
                        first_tx_cyc = cyc;
                        armed        = 1'b0;
                    end
                    if (sbq.size() == 0) begin
                        check("egress_unexpected", 64'(bus.port_transmit_data_valid), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("egress_data", 64'(bus.port_transmit_data), 64'(e.data));
                        check("egress_mask", 64'(bus.port_transmit_data_valid), 64'(e.mask));
                    end
                end
                if (bus.cam_write_valid) begin
                    writes++;
                    last_wkey = bus.cam_write_key;
                    last_widx = bus.cam_write_index;
                    cam_tab[bus.cam_write_key] = int'(bus.cam_write_index);
                end
                if (bus.cam_lookup_valid) begin
                    lookups++;
                    lookup_cyc = cyc;
                    last_lkey  = bus.cam_lookup_key;
                    armed      = 1'b1;
                    if (!cam_silent) begin
                        if (cam_tab.exists(bus.cam_lookup_key)) begin
                            bus.cam_match_valid = 1'b1;
                            bus.cam_match_index = 2'(cam_tab[bus.cam_lookup_key]);
                        end else begin
                            bus.cam_no_match = 1'b1;
                        end
                    end
                end
            end
            for (int p = 0; p < N; p++) begin
                bus.port_receive_data_valid[p] = rst_n && (rxq[p].size() != 0);
                bus.port_receive_data[p]       = bus.port_receive_data_valid[p] ? rxq[p][0] : 9'd0;
                fired[p] = bus.port_receive_data_valid[p] && bus.port_receive_data_ready[p];
            end
        end
    end

    task automatic send_frame(input int port, input logic [47:0] dst, input logic [47:0] src,
                              input int plen, input logic [3:0] emask);
        logic [7:0] hdr [12];
        logic [8:0] b;
        int         total;
        total = 12 + plen;
        for (int i = 0; i < 6; i++) begin
            hdr[i]     = dst[47-8*i -: 8];
            hdr[6 + i] = src[47-8*i -: 8];
        end
        for (int i = 0; i < total; i++) begin
            b[7:0] = (i < 12) ? hdr[i] : 8'(8'hA0 + i);
            b[8]   = (i == total - 1);
            rxq[port].push_back(b);
            if (emask != '0) sbq.push_back('{data: b, mask: emask});
        end
    endtask

    task automatic send_runt(input int port, input int len);
        for (int i = 0; i < len; i++) rxq[port].push_back({i == len - 1, 8'(8'h10 + i)});
    endtask

    task automatic wait_done(input int port);
        int n;
        n = 0;
        while ((rxq[port].size() != 0 || sbq.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_completes", 64'(n < 400), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs [7];
        int   w0, l0, n;
        int   exp_order [6];
        exp_order = '{0, 1, 3, 0, 1, 3};

        //          port dst                src                plen en     sil mask   learn fwd fld drp
        vecs[0] = '{1, 48'h020000000099, 48'h001122334455, 3, 4'hF, 0, 4'b1101, 1, 0, 1, 0};
        vecs[1] = '{0, 48'h001122334455, 48'h00AABBCCDD01, 4, 4'hF, 0, 4'b0010, 1, 1, 1, 0};
        vecs[2] = '{2, 48'hFFFFFFFFFFFF, 48'h000000000022, 2, 4'hF, 0, 4'b1011, 1, 1, 2, 0};
        vecs[3] = '{0, 48'h020000000077, 48'h00AABBCCDD01, 1, 4'h7, 1, 4'b0110, 1, 1, 3, 0};
        vecs[4] = '{1, 48'h00AABBCCDD01, 48'h000000000044, 0, 4'hF, 0, 4'b0001, 1, 2, 3, 0};
        vecs[5] = '{0, 48'h00AABBCCDD01, 48'h000000000055, 2, 4'hF, 0, 4'b0000, 1, 2, 3, 1};
        vecs[6] = '{3, 48'h01005E000001, 48'h010000000033, 1, 4'hF, 0, 4'b0111, 0, 2, 3, 1};

        bus.port_enable_mask = 4'hF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.port_receive_data_ready), 64'd0);
        check("rst_tx_valid", 64'(bus.port_transmit_data_valid), 64'd0);
        check("rst_tx_data", 64'(bus.port_transmit_data), 64'd0);
        check("rst_lookup_valid", 64'(bus.cam_lookup_valid), 64'd0);
        check("rst_write_valid", 64'(bus.cam_write_valid), 64'd0);
        check("rst_counters", 64'({fwd_cnt, fld_cnt, drp_cnt}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            w0 = writes;
            l0 = lookups;
            bus.port_enable_mask = vecs[k].en;
            cam_silent           = vecs[k].silent;
            send_frame(vecs[k].port, vecs[k].dst, vecs[k].src, vecs[k].plen, vecs[k].exp_mask);
            wait_done(vecs[k].port);
            check("lookup_count", 64'(lookups - l0), 64'd1);
            check("lookup_key", 64'(last_lkey), 64'(vecs[k].dst));
            check("learn_count", 64'(writes - w0), 64'(vecs[k].exp_learn));
            if (vecs[k].exp_learn) begin
                check("learn_key", 64'(last_wkey), 64'(vecs[k].src));
                check("learn_index", 64'(last_widx), 64'(vecs[k].port));
            end
            if (vecs[k].silent) check("timeout_latency", 64'(first_tx_cyc - lookup_cyc), 64'd17);
            check("forwarded_count", 64'(fwd_cnt), 64'(vecs[k].exp_fwd));
            check("flooded_count", 64'(fld_cnt), 64'(vecs[k].exp_fld));
            check("dropped_count", 64'(drp_cnt), 64'(vecs[k].exp_drp));
        end
        bus.port_enable_mask = 4'hF;
        cam_silent           = 1'b0;

        // Runt: ends before the header is complete, never reaches the CAM
        l0 = lookups;
        send_runt(2, 8);
        wait_done(2);
        check("runt_no_lookup", 64'(lookups), 64'(l0));
        check("runt_dropped", 64'(drp_cnt), 64'd2);
        check("runt_idle_ready", 64'(bus.port_receive_data_ready), 64'd0);

        // Fairness after reset; six runts also saturate the 2-bit drop counter
        rst_n = 1'b0;
        for (int p = 0; p < N; p++) rxq[p].delete();
        sbq.delete();
        grant_log.delete();
        @(posedge clk); #1;
        check("rst2_counters", 64'({fwd_cnt, fld_cnt, drp_cnt}), 64'd0);
        check("rst2_ready", 64'(bus.port_receive_data_ready), 64'd0);
        bus.port_enable_mask = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            send_runt(0, 3);
            send_runt(1, 3);
            send_runt(3, 3);
        end
        send_runt(2, 3);
        rst_n = 1'b1;
        n = 0;
        while ((rxq[0].size() + rxq[1].size() + rxq[3].size()) != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("fair_completes", 64'(n < 400), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("grant_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("grant_order", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFF, 64'(exp_order[i]));
        end
        check("disabled_port_untouched", 64'(rxq[2].size()), 64'd3);
        check("dropped_saturates", 64'(drp_cnt), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors + 1, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
